// File: rtl/matmul_sequencer.sv
// Sequencer and MAC datapath computing C = A x B from external synchronous-read memories.
// Each C element takes N+2 cycles (N reads, one drain, one write); a full run takes N*N*(N+2) cycles.
// No backpressure: reads and writes are fixed-rate strobes, and a start while busy is ignored.
module matmul_sequencer #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  localparam int ADDR_W = $clog2(N*N)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              c_wr_en,
  output logic [ADDR_W-1:0] c_addr,
  output logic [ACC_W-1:0]  c_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  cycle_count,
  output logic [ACC_W-1:0]  result_sum
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N - 1);
  localparam logic [ACC_W-1:0]  CNT_MAX = '1;

  state_t              state;
  logic [ADDR_W-1:0]   i, j, k;
  logic [ADDR_W-1:0]   ni, nj;
  logic [ACC_W-1:0]    acc, acc_next;
  logic                rd_q, first_q;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;

  // Row-major element address r*N+c.
  function automatic logic [ADDR_W-1:0] idx(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] c);
    return ADDR_W'(int'(r) * N + int'(c));
  endfunction

  assign prod     = {{DATA_W{1'b0}}, a_data} * {{DATA_W{1'b0}}, b_data};
  assign prod_ext = ACC_W'(prod);

  // Next accumulator value: memory data arrives one cycle after each read strobe.
  always_comb begin
    acc_next = acc;
    if (rd_q) acc_next = first_q ? prod_ext : acc + prod_ext;
  end

  // Next output element position, row-major over (i, j).
  always_comb begin
    nj = j + 1'b1;
    ni = i;
    if (j == LAST) begin
      nj = '0;
      ni = i + 1'b1;
    end
  end

  // Accumulator plus the read-strobe pipeline that tracks when data is valid.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      rd_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      rd_q    <= rd_en;
      first_q <= rd_en && (k == '0);
      if ((state == IDLE || state == DONE) && start) acc <= '0;
      else acc <= acc_next;
    end
  end

  // Control FSM with registered strobes, addresses and result counters.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      rd_en       <= 1'b0;
      c_wr_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      a_addr      <= '0;
      b_addr      <= '0;
      c_addr      <= '0;
      c_data      <= '0;
      cycle_count <= '0;
      result_sum  <= '0;
    end else begin
      if (busy && cycle_count != CNT_MAX) cycle_count <= cycle_count + 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            rd_en       <= 1'b1;
            a_addr      <= '0;
            b_addr      <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            result_sum  <= '0;
            cycle_count <= '0;
          end
        end
        RUN: begin
          if (k == LAST) begin
            state <= DRAIN;
            k     <= '0;
            rd_en <= 1'b0;
          end else begin
            k      <= k + 1'b1;
            a_addr <= idx(i, k + 1'b1);
            b_addr <= idx(k + 1'b1, j);
          end
        end
        DRAIN: begin
          state   <= WRITE;
          c_wr_en <= 1'b1;
          c_addr  <= idx(i, j);
          c_data  <= acc_next;
        end
        WRITE: begin
          c_wr_en    <= 1'b0;
          result_sum <= result_sum + acc;
          if (i == LAST && j == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state  <= RUN;
            i      <= ni;
            j      <= nj;
            rd_en  <= 1'b1;
            a_addr <= idx(ni, '0);
            b_addr <= idx('0, nj);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
module tb_matmul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [7:0] amem [16];
  logic [7:0] bmem [16];

  int total = 0;
  int fails = 0;

  typedef struct {int addr; int data;} wr_t;
  typedef struct {int a; int b;} ab_t;
  wr_t q2[$];
  wr_t q4[$];
  wr_t qv[$];
  ab_t qa4[$];
  int rd_cnt2, wr_cnt2;

  // N=2, ACC_W=24 instance
  logic st2, rd2, we2, busy2, done2;
  logic [1:0] aa2, ba2, ca2;
  logic [7:0] ad2, bd2;
  logic [23:0] cd2, cc2, rs2;
  // N=4, ACC_W=24 instance
  logic st4, rd4, we4, busy4, done4;
  logic [3:0] aa4, ba4, ca4;
  logic [7:0] ad4, bd4;
  logic [23:0] cd4, cc4, rs4;
  // N=2, ACC_W=16 instance
  logic stv, rdv, wev, busyv, donev;
  logic [1:0] aav, bav, cav;
  logic [7:0] adv, bdv;
  logic [15:0] cdv, ccv, rsv;

  matmul_sequencer #(.N(2), .DATA_W(8), .ACC_W(24)) d2 (
    .CLOCK_50(clk), .reset(rst), .start(st2), .a_addr(aa2), .b_addr(ba2), .rd_en(rd2),
    .a_data(ad2), .b_data(bd2), .c_wr_en(we2), .c_addr(ca2), .c_data(cd2), .busy(busy2),
    .done(done2), .cycle_count(cc2), .result_sum(rs2));

  matmul_sequencer #(.N(4), .DATA_W(8), .ACC_W(24)) d4 (
    .CLOCK_50(clk), .reset(rst), .start(st4), .a_addr(aa4), .b_addr(ba4), .rd_en(rd4),
    .a_data(ad4), .b_data(bd4), .c_wr_en(we4), .c_addr(ca4), .c_data(cd4), .busy(busy4),
    .done(done4), .cycle_count(cc4), .result_sum(rs4));

  matmul_sequencer #(.N(2), .DATA_W(8), .ACC_W(16)) dv (
    .CLOCK_50(clk), .reset(rst), .start(stv), .a_addr(aav), .b_addr(bav), .rd_en(rdv),
    .a_data(adv), .b_data(bdv), .c_wr_en(wev), .c_addr(cav), .c_data(cdv), .busy(busyv),
    .done(donev), .cycle_count(ccv), .result_sum(rsv));

  // Synchronous-read memory models: data one cycle after the strobe.
  always @(posedge clk) begin
    if (rd2) begin ad2 <= amem[aa2]; bd2 <= bmem[ba2]; end
    if (rd4) begin ad4 <= amem[aa4]; bd4 <= bmem[ba4]; end
    if (rdv) begin adv <= amem[aav]; bdv <= bmem[bav]; end
  end

  // Scoreboard monitors: pop expected C writes / read addresses as the DUTs produce them.
  always @(negedge clk) begin
    wr_t e;
    ab_t p;
    if (rd2) rd_cnt2++;
    if (we2) begin
      wr_cnt2++;
      total++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL c_write_n2 unexpected write addr=%0d data=%0d", ca2, cd2);
      end else begin
        e = q2.pop_front();
        if (ca2 !== e.addr[1:0] || cd2 !== e.data[23:0]) begin
          fails++;
          $display("FAIL c_write_n2 got addr=%0d data=%0d want addr=%0d data=%0d", ca2, cd2, e.addr, e.data);
        end
      end
    end
    if (we4) begin
      total++;
      if (q4.size() == 0) begin
        fails++;
        $display("FAIL c_write_n4 unexpected write addr=%0d data=%0d", ca4, cd4);
      end else begin
        e = q4.pop_front();
        if (ca4 !== e.addr[3:0] || cd4 !== e.data[23:0]) begin
          fails++;
          $display("FAIL c_write_n4 got addr=%0d data=%0d want addr=%0d data=%0d", ca4, cd4, e.addr, e.data);
        end
      end
    end
    if (rd4) begin
      total++;
      if (qa4.size() == 0) begin
        fails++;
        $display("FAIL ab_addr_n4 unexpected read a=%0d b=%0d", aa4, ba4);
      end else begin
        p = qa4.pop_front();
        if (aa4 !== p.a[3:0] || ba4 !== p.b[3:0]) begin
          fails++;
          $display("FAIL ab_addr_n4 got a=%0d b=%0d want a=%0d b=%0d", aa4, ba4, p.a, p.b);
        end
      end
    end
    if (wev) begin
      total++;
      if (qv.size() == 0) begin
        fails++;
        $display("FAIL c_write_ovf unexpected write addr=%0d data=%0d", cav, cdv);
      end else begin
        e = qv.pop_front();
        if (cav !== e.addr[1:0] || cdv !== e.data[15:0]) begin
          fails++;
          $display("FAIL c_write_ovf got addr=%0d data=%0d want addr=%0d data=%0d", cav, cdv, e.addr, e.data);
        end
      end
    end
  end

  // Reference model: push the expected C writes (and, for N=4, read addresses).
  task automatic push_c(input int n, input int w, input int sel);
    longint acc;
    longint mask;
    wr_t e;
    ab_t p;
    mask = (longint'(1) << w) - 1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < n; k++) begin
          acc = acc + longint'(amem[i*n+k]) * longint'(bmem[k*n+j]);
          p.a = i*n+k;
          p.b = k*n+j;
          if (sel == 4) qa4.push_back(p);
        end
        e.addr = i*n+j;
        e.data = int'(acc & mask);
        case (sel)
          2: q2.push_back(e);
          4: q4.push_back(e);
          default: qv.push_back(e);
        endcase
      end
    end
  endtask

  task automatic load_n2();
    for (int x = 0; x < 16; x++) begin amem[x] = 8'd0; bmem[x] = 8'd0; end
    amem[0] = 8'd1; amem[1] = 8'd2; amem[2] = 8'd3; amem[3] = 8'd4;
    bmem[0] = 8'd5; bmem[1] = 8'd6; bmem[2] = 8'd7; bmem[3] = 8'd8;
  endtask

  task automatic pulse(input int sel);
    @(negedge clk);
    case (sel) 2: st2 = 1'b1; 4: st4 = 1'b1; default: stv = 1'b1; endcase
    @(negedge clk);
    st2 = 1'b0; st4 = 1'b0; stv = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int budget);
    logic d;
    d = 1'b0;
    for (int c = 0; c < budget && !d; c++) begin
      @(negedge clk);
      case (sel) 2: d = done2; 4: d = done4; default: d = donev; endcase
    end
    if (!d) begin
      total++;
      fails++;
      $display("FAIL wait_done sel=%0d done not seen within %0d cycles", sel, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if ({rd2, we2, busy2, done2} !== 4'b0) begin fails++; $display("FAIL reset_strobes got %b want 0000", {rd2, we2, busy2, done2}); end
    total++; if ({aa2, ba2, ca2} !== 6'b0) begin fails++; $display("FAIL reset_addrs got %h want 0", {aa2, ba2, ca2}); end
    total++; if (cd2 !== 24'd0 || cc2 !== 24'd0 || rs2 !== 24'd0) begin fails++; $display("FAIL reset_values got c=%0d cnt=%0d sum=%0d want 0", cd2, cc2, rs2); end
    total++; if ({busy4, done4, rd4, busyv, donev, rdv} !== 6'b0) begin fails++; $display("FAIL reset_others got %b want 0", {busy4, done4, rd4, busyv, donev, rdv}); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    wr_t e;
    load_n2();
    e.addr = 0; e.data = 19;
    q2.push_back(e);
    pulse(2);
    repeat (3) @(negedge clk);
    total++; if (cc2 !== 24'd3 || busy2 !== 1'b1) begin fails++; $display("FAIL midrun_before got cnt=%0d busy=%b want 3 1", cc2, busy2); end
    #2;
    rst = 1'b1;
    #1;
    total++; if ({rd2, we2, busy2, done2} !== 4'b0) begin fails++; $display("FAIL midrun_strobes got %b want 0000", {rd2, we2, busy2, done2}); end
    total++; if (cc2 !== 24'd0 || cd2 !== 24'd0 || ca2 !== 2'd0) begin fails++; $display("FAIL midrun_values got cnt=%0d c=%0d ca=%0d want 0", cc2, cd2, ca2); end
    total++; if (q2.size() != 0) begin fails++; $display("FAIL midrun_first_write got %0d pending want 0", q2.size()); end
    @(negedge clk);
    rst = 1'b0;
    q2.delete();
  endtask

  task automatic test_n2();
    load_n2();
    push_c(2, 24, 2);
    rd_cnt2 = 0;
    wr_cnt2 = 0;
    pulse(2);
    wait_done(2, 100);
    total++; if (rs2 !== 24'd134) begin fails++; $display("FAIL n2_sum got %0d want 134", rs2); end
    total++; if (cc2 !== 24'd16) begin fails++; $display("FAIL n2_cycles got %0d want 16", cc2); end
    total++; if (done2 !== 1'b1 || busy2 !== 1'b0) begin fails++; $display("FAIL n2_status got done=%b busy=%b want 1 0", done2, busy2); end
    total++; if (rd_cnt2 != 8) begin fails++; $display("FAIL n2_rd_cycles got %0d want 8", rd_cnt2); end
    total++; if (wr_cnt2 != 4) begin fails++; $display("FAIL n2_wr_cycles got %0d want 4", wr_cnt2); end
    total++; if (q2.size() != 0) begin fails++; $display("FAIL n2_pending got %0d want 0", q2.size()); end
    repeat (3) @(negedge clk);
    total++; if (rs2 !== 24'd134 || cc2 !== 24'd16 || done2 !== 1'b1) begin fails++; $display("FAIL n2_hold got sum=%0d cnt=%0d done=%b", rs2, cc2, done2); end
  endtask

  task automatic test_identity_n4();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        amem[r*4+c] = (r == c) ? 8'd1 : 8'd0;
        bmem[r*4+c] = 8'(4*r + c);
      end
    push_c(4, 24, 4);
    pulse(4);
    wait_done(4, 200);
    total++; if (rs4 !== 24'd120) begin fails++; $display("FAIL n4_sum got %0d want 120", rs4); end
    total++; if (cc4 !== 24'd96) begin fails++; $display("FAIL n4_cycles got %0d want 96", cc4); end
    total++; if (q4.size() != 0 || qa4.size() != 0) begin fails++; $display("FAIL n4_pending got c=%0d ab=%0d want 0 0", q4.size(), qa4.size()); end
  endtask

  task automatic test_overflow();
    for (int x = 0; x < 16; x++) begin amem[x] = 8'd255; bmem[x] = 8'd255; end
    push_c(2, 16, 1);
    pulse(1);
    wait_done(1, 100);
    total++; if (rsv !== 16'd61448) begin fails++; $display("FAIL ovf_sum got %0d want 61448", rsv); end
    total++; if (ccv !== 16'd16) begin fails++; $display("FAIL ovf_cycles got %0d want 16", ccv); end
    total++; if (qv.size() != 0) begin fails++; $display("FAIL ovf_pending got %0d want 0", qv.size()); end
  endtask

  task automatic test_start_busy();
    load_n2();
    push_c(2, 24, 2);
    pulse(2);
    repeat (3) @(negedge clk);
    pulse(2);
    wait_done(2, 100);
    total++; if (rs2 !== 24'd134 || cc2 !== 24'd16) begin fails++; $display("FAIL busy_ignore got sum=%0d cnt=%0d want 134 16", rs2, cc2); end
    total++; if (q2.size() != 0) begin fails++; $display("FAIL busy_pending got %0d want 0", q2.size()); end
    push_c(2, 24, 2);
    pulse(2);
    total++; if (done2 !== 1'b0 || busy2 !== 1'b1) begin fails++; $display("FAIL restart_status got done=%b busy=%b want 0 1", done2, busy2); end
    total++; if (rs2 !== 24'd0 || cc2 !== 24'd0) begin fails++; $display("FAIL restart_clear got sum=%0d cnt=%0d want 0 0", rs2, cc2); end
    wait_done(2, 100);
    total++; if (rs2 !== 24'd134 || cc2 !== 24'd16) begin fails++; $display("FAIL restart_run got sum=%0d cnt=%0d want 134 16", rs2, cc2); end
    total++; if (q2.size() != 0) begin fails++; $display("FAIL restart_pending got %0d want 0", q2.size()); end
  endtask

  initial begin
    st2 = 1'b0; st4 = 1'b0; stv = 1'b0;
    for (int x = 0; x < 16; x++) begin amem[x] = 8'd0; bmem[x] = 8'd0; end
    test_reset();
    test_reset_mid_run();
    test_n2();
    test_identity_n4();
    test_overflow();
    test_start_busy();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end

endmodule
